// File: rtl/renode_memory_pkg.sv
// Shared AXI4-Lite request/response types, response codes and bridge FSM state
// encoding for the TCDM memory bridge.
package renode_memory_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] aw_addr;
        logic                  aw_valid;
        logic [AXI_DATA_W-1:0] w_data;
        logic [AXI_STRB_W-1:0] w_strb;
        logic                  w_valid;
        logic                  b_ready;
        logic [AXI_ADDR_W-1:0] ar_addr;
        logic                  ar_valid;
        logic                  r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic                  aw_ready;
        logic                  w_ready;
        logic                  ar_ready;
        logic                  b_valid;
        logic [1:0]            b_resp;
        logic                  r_valid;
        logic [AXI_DATA_W-1:0] r_data;
        logic [1:0]            r_resp;
    } axi_lite_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_ERR_WR,
        ST_ERR_RD
    } bridge_state_e;

endpackage

// File: rtl/axi_tcdm_hold_reg.sv
// One-entry valid/ready holding register for an AXI channel payload; the
// consumer empties it with clear_i once the payload has been used.
module axi_tcdm_hold_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data_q, data_d;

    // ready is a registered copy of "will be empty", so it reads 0 during reset
    // and first rises on the clock after release.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end
        if (valid_i && ready_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
        ready_d = ~full_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi_tcdm_bridge.sv
// AXI4-Lite slave to TCDM master bridge: single-beat accesses, one TCDM
// transaction in flight, round-robin between eligible write and read.
module axi_tcdm_bridge
    import renode_memory_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_1000),
    parameter int unsigned       MEM_BYTES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  axi_lite_req_t         axi_req_i,
    output axi_lite_resp_t        axi_resp_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_W-1:0]     tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [DATA_W/8-1:0]   tcdm_be_o,
    output logic [DATA_W-1:0]     tcdm_data_o,
    input  logic [DATA_W-1:0]     tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i
);

    localparam int unsigned       STRB_W     = DATA_W / 8;
    localparam int unsigned       WP_W       = DATA_W + STRB_W;
    localparam logic [ADDR_W:0]   WIN_LO     = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   WIN_HI     = WIN_LO + (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

    bridge_state_e state_q, state_d;
    logic          rr_q, rr_d;              // 0: write wins a tie, 1: read wins
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              aw_ready, aw_full, aw_clear;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_ready, w_full, w_clear;
    logic [WP_W-1:0]   w_payload_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              ar_ready, ar_full, ar_clear;
    logic [ADDR_W-1:0] ar_addr_q;

    axi_tcdm_hold_reg #(.W(ADDR_W)) u_aw_hold (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (axi_req_i.aw_valid),
        .ready_o (aw_ready),
        .data_i  (axi_req_i.aw_addr[ADDR_W-1:0]),
        .clear_i (aw_clear),
        .full_o  (aw_full),
        .data_o  (aw_addr_q)
    );

    axi_tcdm_hold_reg #(.W(WP_W)) u_w_hold (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (axi_req_i.w_valid),
        .ready_o (w_ready),
        .data_i  ({axi_req_i.w_data[DATA_W-1:0], axi_req_i.w_strb[STRB_W-1:0]}),
        .clear_i (w_clear),
        .full_o  (w_full),
        .data_o  (w_payload_q)
    );

    axi_tcdm_hold_reg #(.W(ADDR_W)) u_ar_hold (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (axi_req_i.ar_valid),
        .ready_o (ar_ready),
        .data_i  (axi_req_i.ar_addr[ADDR_W-1:0]),
        .clear_i (ar_clear),
        .full_o  (ar_full),
        .data_o  (ar_addr_q)
    );

    assign w_data_q = w_payload_q[WP_W-1:STRB_W];
    assign w_strb_q = w_payload_q[STRB_W-1:0];

    function automatic logic in_window(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] a;
        a = {1'b0, addr};
        return (a >= WIN_LO) && (a < WIN_HI);
    endfunction

    // Arbitration looks through to payloads being handshaken this cycle so the
    // TCDM request can go out on the very next clock.
    logic              wr_elig, rd_elig;
    logic [ADDR_W-1:0] aw_addr_next, ar_addr_next;

    always_comb begin
        wr_elig      = (aw_full || (axi_req_i.aw_valid && aw_ready)) &&
                       (w_full  || (axi_req_i.w_valid  && w_ready));
        rd_elig      = ar_full || (axi_req_i.ar_valid && ar_ready);
        aw_addr_next = aw_full ? aw_addr_q : axi_req_i.aw_addr[ADDR_W-1:0];
        ar_addr_next = ar_full ? ar_addr_q : axi_req_i.ar_addr[ADDR_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        rdata_d  = rdata_q;
        aw_clear = 1'b0;
        w_clear  = 1'b0;
        ar_clear = 1'b0;

        tcdm_req_o  = 1'b0;
        tcdm_wen_o  = 1'b1;
        tcdm_add_o  = '0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;

        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.ar_ready = ar_ready;

        case (state_q)
            ST_IDLE: begin
                if (wr_elig && rd_elig) begin
                    rr_d = ~rr_q;
                end
                if (wr_elig && (!rd_elig || !rr_q)) begin
                    state_d = in_window(aw_addr_next) ? ST_WR_REQ : ST_ERR_WR;
                end else if (rd_elig) begin
                    state_d = in_window(ar_addr_next) ? ST_RD_REQ : ST_ERR_RD;
                end
            end
            ST_WR_REQ: begin
                tcdm_req_o  = 1'b1;
                tcdm_wen_o  = 1'b0;
                tcdm_add_o  = aw_addr_q & ALIGN_MASK;
                tcdm_be_o   = w_strb_q;
                tcdm_data_o = w_data_q;
                if (tcdm_gnt_i) begin
                    aw_clear = 1'b1;
                    w_clear  = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b_resp  = RESP_OKAY;
                if (axi_req_i.b_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                tcdm_req_o = 1'b1;
                tcdm_wen_o = 1'b1;
                tcdm_add_o = ar_addr_q & ALIGN_MASK;
                tcdm_be_o  = '1;
                if (tcdm_gnt_i) begin
                    ar_clear = 1'b1;
                    state_d  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (tcdm_r_valid_i) begin
                    rdata_d = tcdm_r_data_i;
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r_data  = AXI_DATA_W'(rdata_q);
                axi_resp_o.r_resp  = RESP_OKAY;
                if (axi_req_i.r_ready) begin
                    state_d = ST_IDLE;
                end
            end
            // Out-of-window accesses hold their payload until the error
            // response is taken, so nothing new is accepted in between.
            ST_ERR_WR: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b_resp  = RESP_SLVERR;
                if (axi_req_i.b_ready) begin
                    aw_clear = 1'b1;
                    w_clear  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_ERR_RD: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r_resp  = RESP_SLVERR;
                if (axi_req_i.r_ready) begin
                    ar_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            rdata_q <= rdata_d;
        end
    end

`ifndef SYNTHESIS
    r_valid_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        tcdm_r_valid_i |-> (state_q == ST_RD_WAIT)
    );
`endif

endmodule

// File: tb/tb_axi_tcdm_bridge.sv
// Self-checking bench for axi_tcdm_bridge: scoreboard of expected AXI responses,
// a behavioural TCDM memory, and one task per scenario.
module tb_axi_tcdm_bridge;
    import renode_memory_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_req_t  axi_req;
    axi_lite_resp_t axi_resp;
    logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [31:0] tcdm_add;
    logic [7:0]  tcdm_be;
    logic [63:0] tcdm_data, tcdm_r_data;
    bit          gnt_en = 1'b1;

    assign tcdm_gnt = tcdm_req & gnt_en;

    axi_tcdm_bridge #(
        .ADDR_W(32), .DATA_W(64), .BASE_ADDR(32'h0000_1000), .MEM_BYTES(4096)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .axi_req_i      (axi_req),
        .axi_resp_o     (axi_resp),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem [logic [31:0]];
    logic [1:0]  exp_b [$];
    logic [65:0] exp_r [$];      // {resp, data}
    bit          tcdm_log [$];   // wen of each granted TCDM request
    logic        rd_pend = 1'b0;
    logic [63:0] rd_pend_data = '0;
    logic [63:0] wr_old;

    // TCDM memory: grant is combinational, read data one cycle after grant.
    initial begin
        tcdm_r_valid = 1'b0;
        tcdm_r_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            tcdm_r_valid = rd_pend;
            tcdm_r_data  = rd_pend ? rd_pend_data : 64'h0;
            rd_pend      = 1'b0;
            if (tcdm_req && tcdm_gnt) begin
                tcdm_log.push_back(tcdm_wen);
                if (tcdm_wen) begin
                    rd_pend      = 1'b1;
                    rd_pend_data = mem.exists(tcdm_add) ? mem[tcdm_add] : 64'h0;
                end else begin
                    wr_old = mem.exists(tcdm_add) ? mem[tcdm_add] : 64'h0;
                    for (int b = 0; b < 8; b++)
                        if (tcdm_be[b]) wr_old[8*b +: 8] = tcdm_data[8*b +: 8];
                    mem[tcdm_add] = wr_old;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents AW+W and/or AR at a negedge, holds each until accepted.
    task automatic drive_axi(input bit do_w, input logic [31:0] waddr, input logic [63:0] wdata,
                             input logic [7:0] wstrb, input bit do_r, input logic [31:0] raddr,
                             output int hs_cyc);
        bit aw_go, w_go, ar_go;
        axi_req.aw_addr  = waddr;
        axi_req.w_data   = wdata;
        axi_req.w_strb   = wstrb;
        axi_req.ar_addr  = raddr;
        axi_req.aw_valid = do_w;
        axi_req.w_valid  = do_w;
        axi_req.ar_valid = do_r;
        hs_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (!(axi_req.aw_valid || axi_req.w_valid || axi_req.ar_valid)) break;
            aw_go  = axi_req.aw_valid && axi_resp.aw_ready;
            w_go   = axi_req.w_valid  && axi_resp.w_ready;
            ar_go  = axi_req.ar_valid && axi_resp.ar_ready;
            hs_cyc = cyc;
            @(negedge clk);
            if (aw_go) axi_req.aw_valid = 1'b0;
            if (w_go)  axi_req.w_valid  = 1'b0;
            if (ar_go) axi_req.ar_valid = 1'b0;
        end
        n_checks++;
        if (axi_req.aw_valid || axi_req.w_valid || axi_req.ar_valid) begin
            n_fail++;
            $display("FAIL handshake_timeout: valids aw/w/ar=%b%b%b still pending, required accepted",
                     axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid);
            axi_req.aw_valid = 1'b0;
            axi_req.w_valid  = 1'b0;
            axi_req.ar_valid = 1'b0;
        end
    endtask

    task automatic get_b(input int max, output bit ok, output logic [1:0] resp);
        ok = 1'b0;
        resp = 2'bxx;
        for (int i = 0; i < max; i++) begin
            if (axi_resp.b_valid && axi_req.b_ready) begin
                ok = 1'b1;
                resp = axi_resp.b_resp;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic get_r(input int max, output bit ok, output logic [65:0] rsp);
        ok = 1'b0;
        rsp = 'x;
        for (int i = 0; i < max; i++) begin
            if (axi_resp.r_valid && axi_req.r_ready) begin
                ok = 1'b1;
                rsp = {axi_resp.r_resp, axi_resp.r_data};
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [105:0] tcdm_vec;
        #1;
        tcdm_vec = {tcdm_req, tcdm_wen, tcdm_add, tcdm_be, tcdm_data};
        n_checks++;
        if (tcdm_vec !== {1'b0, 1'b1, 32'h0, 8'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_tcdm: got %h required %h", tcdm_vec, {1'b0, 1'b1, 104'h0});
        end
        n_checks++;
        if (axi_resp !== '0) begin
            n_fail++;
            $display("FAIL reset_axi: got %h required 0", axi_resp);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_before_clock: got %b required 000",
                     {axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_clock: got %b required 111",
                     {axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready});
        end
    endtask

    task automatic test_write_latency();
        int n;
        logic [105:0] got;
        logic [1:0] eb;
        exp_b.push_back(RESP_OKAY);
        drive_axi(1'b1, 32'h10C0, 64'h100, 8'hFF, 1'b0, 32'h0, n);
        got = {tcdm_req, tcdm_wen, tcdm_add, tcdm_be, tcdm_data};
        n_checks++;
        if (cyc != n + 1 || got !== {1'b1, 1'b0, 32'h10C0, 8'hFF, 64'h100}) begin
            n_fail++;
            $display("FAIL write_req_n1: got %h at +%0d required %h at +1", got, cyc - n,
                     {1'b1, 1'b0, 32'h10C0, 8'hFF, 64'h100});
        end
        @(negedge clk);
        eb = exp_b.pop_front();
        n_checks++;
        if (axi_resp.b_valid !== 1'b1 || axi_resp.b_resp !== eb) begin
            n_fail++;
            $display("FAIL write_bvalid_n2: got valid=%b resp=%b required valid=1 resp=%b",
                     axi_resp.b_valid, axi_resp.b_resp, eb);
        end
        @(negedge clk);
        n_checks++;
        if (axi_resp.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_bvalid_drop: got %b required 0", axi_resp.b_valid);
        end
    endtask

    task automatic test_read_latency();
        int n;
        logic [41:0] got;
        logic [65:0] er;
        exp_r.push_back({RESP_OKAY, 64'h100});
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h10C0, n);
        got = {tcdm_req, tcdm_wen, tcdm_add, tcdm_be};
        n_checks++;
        if (got !== {1'b1, 1'b1, 32'h10C0, 8'hFF}) begin
            n_fail++;
            $display("FAIL read_req_n1: got %h required %h", got, {1'b1, 1'b1, 32'h10C0, 8'hFF});
        end
        @(negedge clk);
        n_checks++;
        if (tcdm_req !== 1'b0 || axi_resp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait_n2: got req=%b rvalid=%b required 0 0", tcdm_req, axi_resp.r_valid);
        end
        @(negedge clk);
        er = exp_r.pop_front();
        n_checks++;
        if (axi_resp.r_valid !== 1'b1 || {axi_resp.r_resp, axi_resp.r_data} !== er) begin
            n_fail++;
            $display("FAIL read_rvalid_n3: got valid=%b resp/data=%h required valid=1 %h",
                     axi_resp.r_valid, {axi_resp.r_resp, axi_resp.r_data}, er);
        end
        @(negedge clk);
        n_checks++;
        if (axi_resp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rvalid_drop: got %b required 0", axi_resp.r_valid);
        end
    endtask

    task automatic test_arbitration();
        int n;
        bit ok;
        logic [1:0] bresp;
        logic [65:0] rsp, er;
        logic [1:0] eb;
        bit exp_order [2];
        for (int pair = 0; pair < 2; pair++) begin
            tcdm_log.delete();
            exp_b.push_back(RESP_OKAY);
            if (pair == 0) begin
                exp_r.push_back({RESP_OKAY, 64'hAAAA_AAAA_AAAA_AAAA});
                exp_order[0] = 1'b0;
                exp_order[1] = 1'b1;
                drive_axi(1'b1, 32'h10C8, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 32'h10C8, n);
                get_b(30, ok, bresp);
                eb = exp_b.pop_front();
                n_checks++;
                if (!ok || bresp !== eb) begin
                    n_fail++;
                    $display("FAIL arb%0d_bresp: got ok=%b resp=%b required ok=1 resp=%b", pair, ok, bresp, eb);
                end
                get_r(30, ok, rsp);
            end else begin
                exp_r.push_back({RESP_OKAY, 64'hAAAA_AAAA_AAAA_AAAA});
                exp_order[0] = 1'b1;
                exp_order[1] = 1'b0;
                drive_axi(1'b1, 32'h10C8, 64'h5555_5555_5555_5555, 8'h0F, 1'b1, 32'h10C8, n);
                get_r(30, ok, rsp);
            end
            er = exp_r.pop_front();
            n_checks++;
            if (!ok || rsp !== er) begin
                n_fail++;
                $display("FAIL arb%0d_rdata: got ok=%b resp/data=%h required %h", pair, ok, rsp, er);
            end
            if (pair == 1) begin
                get_b(30, ok, bresp);
                eb = exp_b.pop_front();
                n_checks++;
                if (!ok || bresp !== eb) begin
                    n_fail++;
                    $display("FAIL arb%0d_bresp: got ok=%b resp=%b required ok=1 resp=%b", pair, ok, bresp, eb);
                end
            end
            n_checks++;
            if (tcdm_log.size() != 2 || tcdm_log[0] != exp_order[0] || tcdm_log[1] != exp_order[1]) begin
                n_fail++;
                $display("FAIL arb%0d_order: got %0d reqs first_wen=%b required 2 reqs first_wen=%b",
                         pair, tcdm_log.size(), (tcdm_log.size() > 0) ? tcdm_log[0] : 1'bx, exp_order[0]);
            end
        end
        // Partial strobe merged into the earlier full word.
        exp_r.push_back({RESP_OKAY, 64'hAAAA_AAAA_5555_5555});
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h10C8, n);
        get_r(30, ok, rsp);
        er = exp_r.pop_front();
        n_checks++;
        if (!ok || rsp !== er) begin
            n_fail++;
            $display("FAIL strobe_merge: got ok=%b resp/data=%h required %h", ok, rsp, er);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [105:0] got;
        logic [105:0] want;
        logic [1:0] eb;
        want = {1'b1, 1'b0, 32'h1100, 8'hF0, 64'h1122_3344_5566_7788};
        gnt_en = 1'b0;
        axi_req.b_ready = 1'b0;
        exp_b.push_back(RESP_OKAY);
        drive_axi(1'b1, 32'h1104, 64'h1122_3344_5566_7788, 8'hF0, 1'b0, 32'h0, n);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) gnt_en = 1'b1;
            got = {tcdm_req, tcdm_wen, tcdm_add, tcdm_be, tcdm_data};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stall_stable[%0d]: got %h required %h", i, got, want);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (axi_resp.b_valid !== 1'b1 || axi_resp.b_resp !== exp_b[0] || tcdm_req !== 1'b0) begin
                n_fail++;
                $display("FAIL bvalid_hold[%0d]: got valid=%b resp=%b req=%b required 1 %b 0",
                         i, axi_resp.b_valid, axi_resp.b_resp, tcdm_req, exp_b[0]);
            end
            @(negedge clk);
        end
        axi_req.b_ready = 1'b1;
        eb = exp_b.pop_front();
        n_checks++;
        if (axi_resp.b_valid !== 1'b1 || axi_resp.b_resp !== eb) begin
            n_fail++;
            $display("FAIL bvalid_release: got valid=%b resp=%b required 1 %b", axi_resp.b_valid, axi_resp.b_resp, eb);
        end
        @(negedge clk);
        n_checks++;
        if (axi_resp.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bvalid_after_ready: got %b required 0", axi_resp.b_valid);
        end
    endtask

    task automatic test_out_of_window();
        int n;
        bit ok;
        logic [1:0] bresp, eb;
        logic [65:0] rsp, er;
        tcdm_log.delete();
        exp_r.push_back({RESP_SLVERR, 64'h0});
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h2000, n);
        get_r(20, ok, rsp);
        er = exp_r.pop_front();
        n_checks++;
        if (!ok || rsp !== er) begin
            n_fail++;
            $display("FAIL oow_read: got ok=%b resp/data=%h required %h", ok, rsp, er);
        end
        exp_b.push_back(RESP_SLVERR);
        drive_axi(1'b1, 32'h0FF8, 64'hFFFF, 8'hFF, 1'b0, 32'h0, n);
        get_b(20, ok, bresp);
        eb = exp_b.pop_front();
        n_checks++;
        if (!ok || bresp !== eb) begin
            n_fail++;
            $display("FAIL oow_write: got ok=%b resp=%b required %b", ok, bresp, eb);
        end
        n_checks++;
        if (tcdm_log.size() != 0) begin
            n_fail++;
            $display("FAIL oow_no_tcdm: got %0d tcdm requests required 0", tcdm_log.size());
        end
        exp_b.push_back(RESP_OKAY);
        drive_axi(1'b1, 32'h1FF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, 32'h0, n);
        get_b(20, ok, bresp);
        eb = exp_b.pop_front();
        n_checks++;
        if (!ok || bresp !== eb) begin
            n_fail++;
            $display("FAIL top_word_write: got ok=%b resp=%b required %b", ok, bresp, eb);
        end
        exp_r.push_back({RESP_OKAY, 64'hDEAD_BEEF_0BAD_F00D});
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h1FF8, n);
        get_r(20, ok, rsp);
        er = exp_r.pop_front();
        n_checks++;
        if (!ok || rsp !== er || tcdm_log.size() != 2) begin
            n_fail++;
            $display("FAIL top_word_read: got ok=%b resp/data=%h reqs=%0d required %h reqs=2",
                     ok, rsp, tcdm_log.size(), er);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        bit ok, saw_r, saw_req;
        logic [105:0] tcdm_vec;
        logic [65:0] rsp, er;
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h10C0, n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tcdm_vec = {tcdm_req, tcdm_wen, tcdm_add, tcdm_be, tcdm_data};
        n_checks++;
        if (tcdm_vec !== {1'b0, 1'b1, 104'h0} || axi_resp !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got tcdm=%h axi=%h required tcdm=%h axi=0",
                     tcdm_vec, axi_resp, {1'b0, 1'b1, 104'h0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tcdm_log.delete();
        saw_r = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw_r   |= (axi_resp.r_valid === 1'b1);
            saw_req |= (tcdm_req === 1'b1);
        end
        n_checks++;
        if (saw_r || saw_req || tcdm_log.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_discard: got rvalid_seen=%b req_seen=%b required 0 0", saw_r, saw_req);
        end
        exp_r.push_back({RESP_OKAY, 64'h100});
        drive_axi(1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 32'h10C0, n);
        get_r(20, ok, rsp);
        er = exp_r.pop_front();
        n_checks++;
        if (!ok || rsp !== er) begin
            n_fail++;
            $display("FAIL post_reset_read: got ok=%b resp/data=%h required %h", ok, rsp, er);
        end
    endtask

    initial begin
        axi_req = '0;
        test_reset();
        axi_req.b_ready = 1'b1;
        axi_req.r_ready = 1'b1;
        test_write_latency();
        test_read_latency();
        test_arbitration();
        test_stall();
        test_out_of_window();
        test_reset_mid_read();
        n_checks++;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d b / %0d r left required 0 0", exp_b.size(), exp_r.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
